bufmem_arbiter: RTL and testbench

Arbiter and sequencer for the floppy subsystem's single-port 1024x8 sector buffer RAM, shared by three masters: the WD1793 buffer port, the SPI DMA pump and the 6502 workhorse CPU. It sits between those masters and the buffer RAM instance. It replaces the ad-hoc address/data muxing with a deterministic policy:

- WD1793 has fixed top priority.
- DMA and CPU share round-robin access, with DMA burst lock and a CPU starvation guard.
- Read data returns one ce cycle later, tagged to the requester.

---
 rtl/bufmem_arbiter_pkg.sv | 17 +
 rtl/bufmem_arbiter_if.sv | 53 +++++
 rtl/bufmem_arbiter.sv | 131 +++++++++++++
 tb/tb_bufmem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bufmem_arbiter_pkg.sv
// Shared floppy-subsystem constants for the sector buffer arbiter:
// buffer owner encoding and DMA lock states.
package bufmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_WD   = 2'd1,
    OWN_DMA  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_e;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_e;

endpackage

// File: rtl/bufmem_arbiter_if.sv
// Request/grant/read-return bundle between the three buffer masters
// (WD1793, SPI DMA, 6502) and the sector buffer arbiter.
interface bufmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 8
);

  logic          wd_req;
  logic          wd_wr;
  logic [AW-1:0] wd_addr;
  logic [DW-1:0] wd_wdata;
  logic          wd_gnt;
  logic          wd_rvalid;

  logic          dma_req;
  logic          dma_wr;
  logic          dma_lock;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;

  logic          cpu_req;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic          cpu_hold;

  logic [DW-1:0] rdata;

  modport slave (
    input  wd_req, wd_wr, wd_addr, wd_wdata,
    input  dma_req, dma_wr, dma_lock, dma_addr, dma_wdata,
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output wd_gnt, wd_rvalid,
    output dma_gnt, dma_rvalid,
    output cpu_gnt, cpu_rvalid, cpu_hold,
    output rdata
  );

  modport master (
    output wd_req, wd_wr, wd_addr, wd_wdata,
    output dma_req, dma_wr, dma_lock, dma_addr, dma_wdata,
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  wd_gnt, wd_rvalid,
    input  dma_gnt, dma_rvalid,
    input  cpu_gnt, cpu_rvalid, cpu_hold,
    input  rdata
  );

endinterface

// File: rtl/bufmem_arbiter.sv
// Single-port sector buffer arbiter: WD1793 has absolute priority, DMA and CPU
// share round-robin with a DMA burst lock and a CPU starvation override.
module bufmem_arbiter
  import bufmem_arbiter_pkg::*;
#(
  parameter int AW           = 10,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  bufmem_arbiter_if.slave bus,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_data,
  output logic            ram_wren,
  output logic            ram_clken,
  input  logic [DW-1:0]   ram_q,
  output logic [1:0]      owner
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  owner_e        win;
  owner_e        rr_last;
  owner_e        pend_owner;
  lock_e         lock_st;
  lock_e         lock_nx;
  logic [7:0]    starve_cnt;
  logic          active;
  logic          win_wr;
  logic          rd_issue;
  logic [DW-1:0] rdata_q;

  assign active = ce & ~reset;

  always_comb begin : pick_winner
    win = OWN_NONE;
    if (active) begin
      if (bus.wd_req)
        win = OWN_WD;
      else if (starve_cnt == STARVE_MAX && bus.cpu_req)
        win = OWN_CPU;
      else if (lock_st == LOCK_LOCKED && bus.dma_req)
        win = OWN_DMA;
      else if (bus.dma_req && bus.cpu_req)
        win = (rr_last == OWN_DMA) ? OWN_CPU : OWN_DMA;
      else if (bus.dma_req)
        win = OWN_DMA;
      else if (bus.cpu_req)
        win = OWN_CPU;
    end
  end

  always_comb begin : ram_mux
    ram_addr = '0;
    ram_data = '0;
    win_wr   = 1'b0;
    case (win)
      OWN_WD: begin
        ram_addr = bus.wd_addr;
        ram_data = bus.wd_wdata;
        win_wr   = bus.wd_wr;
      end
      OWN_DMA: begin
        ram_addr = bus.dma_addr;
        ram_data = bus.dma_wdata;
        win_wr   = bus.dma_wr;
      end
      OWN_CPU: begin
        ram_addr = bus.cpu_addr;
        ram_data = bus.cpu_wdata;
        win_wr   = bus.cpu_wr;
      end
      default: ;
    endcase
  end

  assign ram_wren  = win_wr;
  assign ram_clken = (win != OWN_NONE);
  assign rd_issue  = ram_clken & ~win_wr;
  assign owner     = win;

  assign bus.wd_gnt   = (win == OWN_WD);
  assign bus.dma_gnt  = (win == OWN_DMA);
  assign bus.cpu_gnt  = (win == OWN_CPU);
  assign bus.cpu_hold = bus.cpu_req & ~bus.cpu_gnt;

  // Read return is visible only on a live ce cycle, so ce gaps and reset swallow it.
  assign bus.wd_rvalid  = active & (pend_owner == OWN_WD);
  assign bus.dma_rvalid = active & (pend_owner == OWN_DMA);
  assign bus.cpu_rvalid = active & (pend_owner == OWN_CPU);
  assign bus.rdata      = rdata_q;

  always_ff @(posedge clk) begin : lock_reg
    if (reset)
      lock_st <= LOCK_UNLOCKED;
    else if (ce)
      lock_st <= lock_nx;
  end

  always_comb begin : lock_next
    lock_nx = lock_st;
    case (lock_st)
      LOCK_UNLOCKED: if (win == OWN_DMA && bus.dma_lock) lock_nx = LOCK_LOCKED;
      LOCK_LOCKED:   if (!bus.dma_lock || !bus.dma_req) lock_nx = LOCK_UNLOCKED;
      default:       lock_nx = LOCK_UNLOCKED;
    endcase
  end

  // WD grants leave the round-robin flag alone so a WD burst cannot skew DMA/CPU fairness.
  always_ff @(posedge clk) begin : seq_state
    if (reset) begin
      rr_last    <= OWN_CPU;
      starve_cnt <= '0;
      pend_owner <= OWN_NONE;
      rdata_q    <= '0;
    end else if (ce) begin
      if (pend_owner != OWN_NONE)
        rdata_q <= ram_q;
      pend_owner <= rd_issue ? win : OWN_NONE;
      if (win == OWN_DMA || win == OWN_CPU)
        rr_last <= win;
      if (bus.cpu_gnt || !bus.cpu_req)
        starve_cnt <= '0;
      else if (starve_cnt < STARVE_MAX)
        starve_cnt <= starve_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bufmem_arbiter.sv
// Randomized bench for bufmem_arbiter against a per-cycle behavioural model
// of the arbitration rules, read pipeline and a reference copy of the buffer RAM.
module tb_bufmem_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int LIMIT = 8;
  localparam int NONE  = 0;
  localparam int WD    = 1;
  localparam int DMA   = 2;
  localparam int CPU   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic          ram_clken;
  logic [DW-1:0] ram_q;
  logic [1:0]    owner;

  bufmem_arbiter_if #(.AW(AW), .DW(DW)) bus();

  bufmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren),
    .ram_clken(ram_clken),
    .ram_q    (ram_q),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] initByte(int i);
    if (i == 10'h005) return 8'hC3;
    if (i == 10'h2A5) return 8'h5A;
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Behavioural single-port RAM with one clock of read latency.
  logic [DW-1:0] ram_mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) ram_mem[i] = initByte(i);
    ram_q = '0;
    forever begin
      @(posedge clk);
      if (ram_clken) begin
        ram_q <= ram_mem[ram_addr];
        if (ram_wren) ram_mem[ram_addr] <= ram_data;
      end
    end
  end

  logic [7:0] ref_mem [1024];
  bit         m_locked    = 1'b0;
  int         m_last      = CPU;
  int         m_starve    = 0;
  int         m_pend      = NONE;
  logic [7:0] m_pend_data = '0;
  logic [7:0] m_rdata     = '0;
  int         prev_win    = NONE;
  int         last_owner  = NONE;
  logic [2:0] last_rv     = '0;
  int         checks      = 0;
  int         errors      = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int modelWinner();
    if (!ce || reset) return NONE;
    if (bus.wd_req) return WD;
    if (m_starve == LIMIT && bus.cpu_req) return CPU;
    if (m_locked && bus.dma_req) return DMA;
    if (bus.dma_req && bus.cpu_req) return (m_last == DMA) ? CPU : DMA;
    if (bus.dma_req) return DMA;
    if (bus.cpu_req) return CPU;
    return NONE;
  endfunction

  function automatic bit winWr(int w);
    case (w)
      WD:      return bus.wd_wr;
      DMA:     return bus.dma_wr;
      CPU:     return bus.cpu_wr;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [AW-1:0] winAddr(int w);
    case (w)
      WD:      return bus.wd_addr;
      DMA:     return bus.dma_addr;
      CPU:     return bus.cpu_addr;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] winData(int w);
    case (w)
      WD:      return bus.wd_wdata;
      DMA:     return bus.dma_wdata;
      CPU:     return bus.cpu_wdata;
      default: return '0;
    endcase
  endfunction

  task automatic modelUpdate(input int w);
    if (reset) begin
      m_locked = 1'b0;
      m_last   = CPU;
      m_starve = 0;
      m_pend   = NONE;
      m_rdata  = '0;
    end else if (ce) begin
      if (m_pend != NONE) m_rdata = m_pend_data;
      if (w != NONE && !winWr(w)) begin
        m_pend      = w;
        m_pend_data = ref_mem[winAddr(w)];
      end else begin
        m_pend = NONE;
      end
      if (w != NONE && winWr(w)) ref_mem[winAddr(w)] = winData(w);
      if (!m_locked) m_locked = (w == DMA) && bus.dma_lock;
      else           m_locked = bus.dma_lock && bus.dma_req;
      if (w == DMA || w == CPU) m_last = w;
      if (bus.cpu_req && w != CPU) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else                         m_starve = 0;
    end
    prev_win = w;
  endtask

  // One clock: check combinational outputs against the model, then the registered read data.
  task automatic applyStimulus();
    int w;
    logic [2:0] exp_rv;
    #1;
    w      = modelWinner();
    exp_rv = (ce && !reset) ? {m_pend == WD, m_pend == DMA, m_pend == CPU} : 3'b000;
    checkOutput("owner", owner, w);
    checkOutput("gnt", {bus.wd_gnt, bus.dma_gnt, bus.cpu_gnt}, {w == WD, w == DMA, w == CPU});
    checkOutput("rvalid", {bus.wd_rvalid, bus.dma_rvalid, bus.cpu_rvalid}, exp_rv);
    checkOutput("cpu_hold", bus.cpu_hold, bus.cpu_req && w != CPU);
    checkOutput("ram_clken", ram_clken, w != NONE);
    checkOutput("ram_wren", ram_wren, w != NONE && winWr(w));
    checkOutput("ram_addr", ram_addr, (w == NONE) ? '0 : winAddr(w));
    if (w != NONE && winWr(w)) checkOutput("ram_data", ram_data, winData(w));
    last_owner = owner;
    last_rv    = {bus.wd_rvalid, bus.dma_rvalid, bus.cpu_rvalid};
    @(posedge clk);
    modelUpdate(w);
    #1;
    checkOutput("rdata", bus.rdata, m_rdata);
  endtask

  task automatic idleInputs();
    reset = 1'b0;
    ce    = 1'b1;
    bus.wd_req  = 1'b0; bus.wd_wr  = 1'b0; bus.wd_addr  = '0; bus.wd_wdata  = '0;
    bus.dma_req = 1'b0; bus.dma_wr = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.dma_lock = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
  endtask

  task automatic resetCycle();
    idleInputs();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
  endtask

  function automatic logic [AW-1:0] randAddr();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return AW'($urandom);
    endcase
  endfunction

  // Outstanding requests keep their address/data stable until granted.
  task automatic randomInputs(input int wd_pct, input int req_pct, input int lock_pct,
                              input int ce_pct, input int rst_pct);
    if (!bus.wd_req || prev_win == WD) begin
      bus.wd_req   = $urandom_range(0, 99) < wd_pct;
      bus.wd_wr    = 1'($urandom);
      bus.wd_addr  = randAddr();
      bus.wd_wdata = DW'($urandom);
    end
    if (!bus.dma_req || prev_win == DMA) begin
      bus.dma_req   = $urandom_range(0, 99) < req_pct;
      bus.dma_wr    = 1'($urandom);
      bus.dma_addr  = randAddr();
      bus.dma_wdata = DW'($urandom);
    end
    if (!bus.cpu_req || prev_win == CPU) begin
      bus.cpu_req   = $urandom_range(0, 99) < req_pct;
      bus.cpu_wr    = 1'($urandom);
      bus.cpu_addr  = randAddr();
      bus.cpu_wdata = DW'($urandom);
    end
    bus.dma_lock = $urandom_range(0, 99) < lock_pct;
    ce           = $urandom_range(0, 99) < ce_pct;
    reset        = $urandom_range(0, 99) < rst_pct;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = initByte(i);
    idleInputs();

    $display("[TB] reset values");
    resetCycle();
    resetCycle();

    $display("[TB] WD and CPU read collision");
    bus.wd_req = 1'b1; bus.wd_addr = 10'h005;
    bus.cpu_req = 1'b1; bus.cpu_addr = 10'h3FF;
    applyStimulus();
    checkOutput("tp1_wd_first", last_owner, WD);
    bus.wd_req = 1'b0;
    applyStimulus();
    checkOutput("tp1_cpu_next", last_owner, CPU);
    checkOutput("tp1_wd_rvalid", last_rv, 3'b100);
    checkOutput("tp1_rdata", bus.rdata, 8'hC3);
    bus.cpu_req = 1'b0;
    applyStimulus();

    $display("[TB] DMA/CPU round-robin writes");
    resetCycle();
    bus.dma_req = 1'b1; bus.dma_wr = 1'b1; bus.dma_addr = 10'h010; bus.dma_wdata = 8'hA1;
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 10'h020; bus.cpu_wdata = 8'hB2;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput("rr_alternate", last_owner, (i % 2 == 0) ? DMA : CPU);
    end

    $display("[TB] locked DMA burst with starving CPU");
    resetCycle();
    bus.dma_req = 1'b1; bus.dma_wr = 1'b1; bus.dma_lock = 1'b1;
    bus.dma_addr = 10'h100; bus.dma_wdata = 8'h11;
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 10'h200; bus.cpu_wdata = 8'h22;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("burst_seq", last_owner, (i == LIMIT) ? CPU : DMA);
    end
    bus.wd_req = 1'b1; bus.wd_addr = 10'h005;
    applyStimulus();
    checkOutput("wd_preempt", last_owner, WD);
    bus.wd_req = 1'b0;
    applyStimulus();
    checkOutput("dma_resume", last_owner, DMA);
    checkOutput("cpu_still_held", bus.cpu_hold, 1'b1);

    $display("[TB] read across ce gap");
    resetCycle();
    bus.cpu_req = 1'b1; bus.cpu_addr = 10'h2A5;
    applyStimulus();
    bus.cpu_req = 1'b0;
    ce = 1'b0;
    applyStimulus();
    checkOutput("gap_rvalid0", last_rv, 3'b000);
    applyStimulus();
    checkOutput("gap_rvalid1", last_rv, 3'b000);
    ce = 1'b1;
    applyStimulus();
    checkOutput("gap_cpu_rvalid", last_rv, 3'b001);
    checkOutput("gap_rdata", bus.rdata, 8'h5A);

    $display("[TB] reset during pending read");
    resetCycle();
    bus.dma_req = 1'b1; bus.dma_addr = 10'h2A5;
    applyStimulus();
    bus.dma_req = 1'b0;
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    applyStimulus();
    checkOutput("dropped_rvalid", last_rv, 3'b000);
    checkOutput("dropped_rdata", bus.rdata, 8'h00);
    applyStimulus();

    $display("[TB] randomized traffic");
    idleInputs();
    for (int i = 0; i < 2400; i++) begin
      if ((i / 200) % 2 == 0) randomInputs(20, 60, 40, 85, 1);
      else                    randomInputs(5, 100, 95, 90, 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
